// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (receiver state encoding, bit-timing helper,
// datapath widths). Also used by uart_tx for the same bit timing.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned DATA_W = 8;   // payload bits per frame
  localparam int unsigned CNT_W  = 16;  // bit-period counter width
  localparam int unsigned IDX_W  = 3;   // data bit index width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per serial bit; integer division, remainder dropped.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-to-consumer bus.
//   rx_data   last good byte, stable until the next rx_valid
//   rx_valid  one-cycle strobe, rx_data updated
//   frame_err one-cycle strobe, stop bit was 0 and the byte was dropped
//   rx_busy   a frame is in progress
// master = receiver side (drives), slave = consumer side.
`timescale 1ns/1ps
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for asynchronous inputs.
//   clk, rst_n  clock, async active-low reset
//   d           asynchronous input
//   q           synchronized output; both stages reset to RST_VAL
`timescale 1ns/1ps
module uart_rx_sync #(
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{RST_VAL}};
      sync_q <= {WIDTH{RST_VAL}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (1 start, 8 data LSB-first, 1 stop, idle high).
//   clk, rst_n  system clock, async active-low reset
//   rx          serial line, asynchronous to clk
//   rx_if       master side of uart_rx_if: rx_data / rx_valid / frame_err / rx_busy
// Bytes arrive as a one-cycle rx_valid strobe; a bad stop bit gives a one-cycle
// frame_err strobe instead and leaves rx_data untouched.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  rx_if
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_W - 1);

  // Bit period must fit the counter and leave room for a mid-bit sample.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_bit_timing
    $error("uart_rx: CLKS_PER_BIT out of range [4, 65535]");
  end

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_count_q, clk_count_d;
  logic [IDX_W-1:0]  bit_index_q, bit_index_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_busy_q, rx_busy_d;

  logic rx_s;    // synchronized line
  logic rx_d_q;  // previous rx_s, for edge detection
  logic fall_c;
  logic half_c;
  logic full_c;

  uart_rx_sync #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Edge register resets high so a line low out of reset is not a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_d_q <= 1'b1;
    else        rx_d_q <= rx_s;
  end

  assign fall_c = rx_d_q && !rx_s;
  assign half_c = (clk_count_q == CNT_HALF_LAST);
  assign full_c = (clk_count_q == CNT_BIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fall_c) state_d = ST_START;
      // A start bit that is high again at mid-bit was a glitch.
      ST_START: if (half_c) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (full_c && (bit_index_q == IDX_LAST)) state_d = ST_STOP;
      // Leave at mid-stop so the next start edge is never missed.
      ST_STOP:  if (full_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    clk_count_d = clk_count_q + CNT_W'(1);
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_busy_d   = (state_d != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
      end
      ST_START: begin
        if (half_c) begin
          clk_count_d = '0;
          bit_index_d = '0;
        end
      end
      ST_DATA: begin
        if (full_c) begin
          shift_d[bit_index_q] = rx_s;
          bit_index_d          = bit_index_q + IDX_W'(1);
          clk_count_d          = '0;
        end
      end
      ST_STOP: begin
        if (full_c) begin
          clk_count_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = rx_busy_q;

endmodule
